// File: rtl/onebit_pkg.sv
// onebit_pkg -- shared constants and types for the one-bit processor program loader.
//
// Contents:
//   INSTR_W    processor instruction width in bits
//   MAX_INSTR  maximum program length in instructions
//   OUT_REGS   number of processor output registers
//   IN_REGS    number of processor input registers (width of the inReg drive)
//   loader_state_t  loader FSM state encoding
package onebit_pkg;

    localparam int INSTR_W   = 13;
    localparam int MAX_INSTR = 16;
    localparam int OUT_REGS  = 7;
    localparam int IN_REGS   = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRST  = 3'd1,
        WAITW = 3'd2,
        SHIFT = 3'd3,
        RUN   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/instr_serializer.sv
// instr_serializer -- parallel-in / serial-out instruction register with bit counter.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset (clears register and counter)
//   load     capture data into the shift register, restart the bit counter
//   shift    advance one bit (MSB leaves first)
//   data     parallel instruction word
//   bit_out  current serial bit (register MSB)
//   last     high while the final bit of the word is being presented
module instr_serializer
    import onebit_pkg::*;
#(
    parameter int WIDTH = INSTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out,
    output logic             last
);

    localparam int BC_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;
    logic [BC_W-1:0]  bc_reg;

    // Next value of the shift register: each position takes its lower
    // neighbour, the vacated LSB fills with zero.
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign sr_next[gi] = sr_reg[gi-1];
        end
    endgenerate
    assign sr_next[0] = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_reg <= '0;
            bc_reg <= '0;
        end else if (load) begin
            sr_reg <= data;
            bc_reg <= '0;
        end else if (shift) begin
            sr_reg <= sr_next;
            bc_reg <= bc_reg + BC_W'(1);
        end
    end

    assign bit_out = sr_reg[WIDTH-1];
    assign last    = (bc_reg == BC_W'(WIDTH - 1));

endmodule

// File: rtl/program_loader.sv
// program_loader -- loads a program into a one-bit serial processor.
//
// A start request (accepted in IDLE or RUN) captures the program length,
// pulses the processor reset for one cycle, then for each instruction waits
// for a parallel word (valid/ready handshake) and shifts it MSB-first into
// the processor over INSTR_W cycles with proc_en high. When all words are in,
// done pulses for one cycle and the block enters RUN, where the user inputs
// drive the processor inReg directly.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   start, prog_len     load request and requested length (clamped to MAX_INSTR)
//   word_data/valid     parallel instruction word source
//   word_ready          high only while waiting for a word
//   usr_in              run-time processor inputs
//   proc_reset          active-high processor reset (PRST, and while reset is low)
//   proc_en, proc_in    processor load enable and inReg drive
//   busy, done          loading in progress / one-cycle completion pulse
//   loaded_count        words loaded since the last accepted start
//   prog_checksum       XOR of accepted words (only with PROG_LOADER_CHECKSUM_EN)
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
module program_loader #(
    parameter int INSTR_W   = onebit_pkg::INSTR_W,
    parameter int MAX_INSTR = onebit_pkg::MAX_INSTR,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   prog_len,
    input  logic [INSTR_W-1:0] word_data,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic [1:0]         usr_in,
    output logic               proc_reset,
    output logic               proc_en,
    output logic [1:0]         proc_in,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   loaded_count
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic [INSTR_W-1:0] prog_checksum
`endif
);

    import onebit_pkg::*;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_INSTR);

    loader_state_t    state_reg, state_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             done_reg, done_next;
    logic             ser_load, ser_shift;
    logic             ser_bit, ser_last;

    instr_serializer #(
        .WIDTH (INSTR_W)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .load    (ser_load),
        .shift   (ser_shift),
        .data    (word_data),
        .bit_out (ser_bit),
        .last    (ser_last)
    );

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        case (state_reg)
            IDLE, RUN: begin
                if (start) begin
                    len_next   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                    count_next = '0;
                    state_next = PRST;
                end
            end
            PRST: begin
                if (len_reg == '0) begin
                    state_next = RUN;
                    done_next  = 1'b1;
                end else begin
                    state_next = WAITW;
                end
            end
            WAITW: begin
                if (word_valid) begin
                    ser_load   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                ser_shift = 1'b1;
                if (ser_last) begin
                    count_next = count_reg + CNT_W'(1);
                    if (count_next == len_reg) begin
                        state_next = RUN;
                        done_next  = 1'b1;
                    end else begin
                        state_next = WAITW;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    // Outputs are additionally qualified by reset so that the processor sees
    // a held reset and a quiet interface for the whole time reset is low,
    // not just from the edge after it is sampled.
    always_comb begin
        word_ready   = reset && (state_reg == WAITW);
        proc_reset   = !reset || (state_reg == PRST);
        proc_en      = reset && (state_reg == SHIFT);
        busy         = reset && ((state_reg == PRST) || (state_reg == WAITW) ||
                                 (state_reg == SHIFT));
        done         = reset && done_reg;
        loaded_count = reset ? count_reg : '0;
        proc_in      = 2'b00;
        if (reset) begin
            if (state_reg == RUN) begin
                proc_in = usr_in;
            end else if (state_reg == SHIFT) begin
                proc_in = {1'b0, ser_bit};
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] checksum_reg;

    always_ff @(posedge clk) begin
        if (!reset || (state_reg == PRST)) begin
            checksum_reg <= '0;
        end else if (ser_load) begin
            checksum_reg <= checksum_reg ^ word_data;
        end
    end

    assign prog_checksum = reset ? checksum_reg : '0;
`endif

endmodule
